iq_symbol_mapper: RTL and testbench

- Downstream consumer of the serial-to-parallel stage.
- Takes each 2+2-bit symbol pair (I bits, Q bits) and Gray-maps each to a signed 4-level amplitude {-3,-1,+1,+3}·SCALE.
- Buffers symbols in a small FIFO and upsamples each to SPS output samples, by hold or zero-stuffing.
- Feeds the pulse-shaping filter over a valid/ready handshake.

---
 rtl/iq_symbol_mapper_pkg.sv | 29 ++
 rtl/iq_symbol_mapper_sync_fifo.sv | 54 +++++
 rtl/iq_symbol_mapper.sv | 138 +++++++++++++
 tb/tb_iq_symbol_mapper.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_symbol_mapper_pkg.sv
// Shared definitions for the IQ symbol mapper: Gray level codes, FSM states,
// and the code-to-level helper.
package iq_symbol_mapper_pkg;

    // Gray codes of the four amplitude levels (adjacent levels differ by one bit)
    localparam logic [1:0] LVL_M3 = 2'b00;
    localparam logic [1:0] LVL_M1 = 2'b01;
    localparam logic [1:0] LVL_P1 = 2'b11;
    localparam logic [1:0] LVL_P3 = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Signed level multiplier in {-3,-1,+1,+3} for a 2-bit Gray code
    function automatic logic signed [2:0] gray_to_level(input logic [1:0] code);
        logic signed [2:0] lvl;
        case (code)
            LVL_M3:  lvl = -3'sd3;
            LVL_M1:  lvl = -3'sd1;
            LVL_P1:  lvl = 3'sd1;
            LVL_P3:  lvl = 3'sd3;
            default: lvl = 3'sd0;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/iq_symbol_mapper_sync_fifo.sv
// Generic synchronous FIFO with registered occupancy count.
// Push is ignored when full, pop is ignored when empty; both may happen on
// the same edge. Read data is the current head entry (valid when not empty).
module sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

endmodule

// File: rtl/iq_symbol_mapper.sv
// Gray-maps I/Q bit pairs to signed 4-level amplitudes, buffers symbols and
// upsamples each to SPS output samples (hold or zero-stuffing).
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; a source holds valid and its data stable until that edge, and ready
// never depends combinationally on valid.
module iq_symbol_mapper #(
    parameter int SPS         = 4,
    parameter int AMP_W       = 8,
    parameter int SCALE       = 32,
    parameter int ZERO_INSERT = 0,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sym_valid,
    output logic                         sym_ready,
    input  logic [1:0]                   sym_i,
    input  logic [1:0]                   sym_q,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [AMP_W-1:0]             out_i,
    output logic [AMP_W-1:0]             out_q,
    output logic                         out_first,
    output logic                         burst_end,
    output logic                         o_dbg_state,
    output logic [$clog2(FIFO_DEPTH):0]  o_dbg_count
);
    import iq_symbol_mapper_pkg::*;

    localparam int PH_W  = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PH_W-1:0]         PH_LAST = PH_W'(SPS - 1);
    localparam logic signed [AMP_W-1:0] W_SCALE = AMP_W'(SCALE);

    state_t            r_state, w_state_nx;
    logic [PH_W-1:0]   r_phase, w_phase_nx;
    logic [3:0]        r_hold,  w_hold_nx;
    logic              r_burst, w_burst_nx;

    logic              w_push;
    logic              w_pop;
    logic [3:0]        w_fifo_data;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CNT_W-1:0]  w_fifo_count;
    logic signed [AMP_W-1:0] w_map_i;
    logic signed [AMP_W-1:0] w_map_q;
    logic              w_emit;
    logic              w_zero;

    // Readiness comes from the registered count only, and is blocked in reset
    assign sym_ready = !rst && !w_fifo_full;
    assign w_push    = sym_valid && sym_ready;

    sync_fifo #(
        .WIDTH (4),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({sym_i, sym_q}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Held symbol: r_hold[3:2] is the I code, r_hold[1:0] the Q code
    assign w_map_i = AMP_W'(gray_to_level(r_hold[3:2])) * W_SCALE;
    assign w_map_q = AMP_W'(gray_to_level(r_hold[1:0])) * W_SCALE;

    assign w_emit    = (r_state == EMIT);
    assign w_zero    = (ZERO_INSERT != 0) && (r_phase != '0);
    assign out_valid = w_emit;
    assign out_first = w_emit && (r_phase == '0);
    assign out_i     = (w_emit && !w_zero) ? w_map_i : '0;
    assign out_q     = (w_emit && !w_zero) ? w_map_q : '0;
    assign burst_end = r_burst;

    assign o_dbg_state = r_state;
    assign o_dbg_count = w_fifo_count;

    // FSM state, phase, held symbol and burst pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_phase <= '0;
            r_hold  <= '0;
            r_burst <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_phase <= w_phase_nx;
            r_hold  <= w_hold_nx;
            r_burst <= w_burst_nx;
        end
    end

    // Next-state: load from FIFO when idle, step phases, chain symbols without a bubble
    always_comb begin
        w_state_nx = r_state;
        w_phase_nx = r_phase;
        w_hold_nx  = r_hold;
        w_burst_nx = 1'b0;
        w_pop      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop      = 1'b1;
                    w_hold_nx  = w_fifo_data;
                    w_phase_nx = '0;
                    w_state_nx = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (r_phase != PH_LAST) begin
                        w_phase_nx = r_phase + PH_W'(1);
                    end else if (!w_fifo_empty) begin
                        w_pop      = 1'b1;
                        w_hold_nx  = w_fifo_data;
                        w_phase_nx = '0;
                    end else begin
                        w_phase_nx = '0;
                        w_state_nx = IDLE;
                        w_burst_nx = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_phase_nx = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_iq_symbol_mapper.sv
// Bench for iq_symbol_mapper: three instances cover hold mode (SPS=4),
// zero-stuffing (SPS=4) and SPS=1, against a queue-based sample model.
module tb_iq_symbol_mapper;

  localparam int AMP_W = 8;
  localparam int SCALE = 32;
  localparam int SPS   = 4;
  localparam int W     = 2 * AMP_W + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // instance 0: SPS=4, hold
  logic sv0, sr0, ov0, or0, of0, be0, st0;
  logic [1:0] si0, sq0;
  logic [AMP_W-1:0] oi0, oq0;
  logic [2:0] dc0;
  // instance 1: SPS=4, zero insert
  logic sv1, sr1, ov1, or1, of1, be1, st1;
  logic [1:0] si1, sq1;
  logic [AMP_W-1:0] oi1, oq1;
  logic [2:0] dc1;
  // instance 2: SPS=1
  logic sv2, sr2, ov2, or2, of2, be2, st2;
  logic [1:0] si2, sq2;
  logic [AMP_W-1:0] oi2, oq2;
  logic [2:0] dc2;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_be = 1'b0;
  logic         stalled = 1'b0;
  logic [W:0]   stall_val;
  bit           gap_watch = 0;
  bit           started = 0;
  int           n_gaps = 0;
  int           n_burst = 0;
  int           n_samples = 0;
  int           n_pushed = 0;

  iq_symbol_mapper #(.SPS(SPS), .AMP_W(AMP_W), .SCALE(SCALE), .ZERO_INSERT(0), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .rst(rst), .sym_valid(sv0), .sym_ready(sr0), .sym_i(si0), .sym_q(sq0),
    .out_valid(ov0), .out_ready(or0), .out_i(oi0), .out_q(oq0), .out_first(of0),
    .burst_end(be0), .o_dbg_state(st0), .o_dbg_count(dc0));

  iq_symbol_mapper #(.SPS(SPS), .AMP_W(AMP_W), .SCALE(SCALE), .ZERO_INSERT(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .sym_valid(sv1), .sym_ready(sr1), .sym_i(si1), .sym_q(sq1),
    .out_valid(ov1), .out_ready(or1), .out_i(oi1), .out_q(oq1), .out_first(of1),
    .burst_end(be1), .o_dbg_state(st1), .o_dbg_count(dc1));

  iq_symbol_mapper #(.SPS(1), .AMP_W(AMP_W), .SCALE(SCALE), .ZERO_INSERT(0), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .sym_valid(sv2), .sym_ready(sr2), .sym_i(si2), .sym_q(sq2),
    .out_valid(ov2), .out_ready(or2), .out_i(oi2), .out_q(oq2), .out_first(of2),
    .burst_end(be2), .o_dbg_state(st2), .o_dbg_count(dc2));

  // clock
  always #5 clk = ~clk;

  // reference: Gray code -> amplitude, by table lookup
  function automatic int level(input logic [1:0] c);
    int t[4];
    t = '{-3, -1, 3, 1};
    return t[c] * SCALE;
  endfunction

  // append the SPS expected hold-mode samples of one accepted symbol
  task automatic add_sym(input logic [1:0] i, input logic [1:0] q);
    logic [AMP_W-1:0] ai, aq;
    ai = AMP_W'(level(i));
    aq = AMP_W'(level(q));
    for (int k = 0; k < SPS; k++) exp_q.push_back({(k == 0), ai, aq});
  endtask

  // one cycle on instance 0, entered and left at a falling edge
  task automatic cyc0(input bit push, input logic [1:0] i, input logic [1:0] q, input bit rdy);
    logic [W-1:0] got, exp;
    logic exp_be_next;
    n_checks++;
    if (be0 !== exp_be) $display("FAIL burst_end: got %b exp %b at %0t", be0, exp_be, $time);
    else n_pass++;
    if (be0 === 1'b1) n_burst++;
    if (stalled) begin
      n_checks++;
      if ({ov0, of0, oi0, oq0} !== stall_val)
        $display("FAIL stall_hold: got %h exp %h at %0t", {ov0, of0, oi0, oq0}, stall_val, $time);
      else n_pass++;
    end
    if (gap_watch && started && exp_q.size() != 0 && ov0 !== 1'b1) n_gaps++;
    if (ov0 === 1'b1) started = 1;
    exp_be_next = 1'b0;
    if (ov0 === 1'b1 && rdy) begin
      n_checks++;
      got = {of0, oi0, oq0};
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_sample: got %h exp none at %0t", got, $time);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) $display("FAIL sample: got %h exp %h at %0t", got, exp, $time);
        else n_pass++;
        exp_be_next = (exp_q.size() == 0);
        n_samples++;
      end
    end
    stalled   = (ov0 === 1'b1) && !rdy;
    stall_val = {ov0, of0, oi0, oq0};
    sv0 = push; si0 = i; sq0 = q; or0 = rdy;
    if (push && sr0 === 1'b1) begin
      add_sym(i, q);
      n_pushed++;
    end
    @(negedge clk);
    exp_be = exp_be_next;
  endtask

  task automatic drain0();
    for (int c = 0; c < 400 && (exp_q.size() != 0 || ov0 === 1'b1); c++) cyc0(0, 2'b00, 2'b00, 1);
    cyc0(0, 2'b00, 2'b00, 1);
    cyc0(0, 2'b00, 2'b00, 1);
    n_checks++;
    if (exp_q.size() != 0 || ov0 !== 1'b0)
      $display("FAIL drain: got pending=%0d valid=%b exp pending=0 valid=0", exp_q.size(), ov0);
    else n_pass++;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({ov0, oi0, oq0, of0, be0, sr0} !== '0)
      $display("FAIL reset_outputs: got %h exp 0", {ov0, oi0, oq0, of0, be0, sr0});
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({sr0, sr1, sr2, ov0, ov1, ov2} !== 6'b111000)
      $display("FAIL reset_release: got %b exp 111000", {sr0, sr1, sr2, ov0, ov1, ov2});
    else n_pass++;
  endtask

  task automatic test_single();
    n_burst = 0; n_samples = 0;
    cyc0(1, 2'b10, 2'b00, 1);
    drain0();
    n_checks++;
    if (n_samples != 4 || n_burst != 1)
      $display("FAIL single_counts: got samples=%0d bursts=%0d exp 4/1", n_samples, n_burst);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int idx, base;
    logic [3:0] code;
    n_burst = 0; n_samples = 0; n_gaps = 0; started = 0; gap_watch = 1;
    idx = 0;
    for (int c = 0; c < 300 && idx < 16; c++) begin
      code = 4'(idx);
      base = n_pushed;
      cyc0(1, code[3:2], code[1:0], 1);
      if (n_pushed != base) idx++;
    end
    drain0();
    gap_watch = 0;
    n_checks++;
    if (n_samples != 64 || n_gaps != 0 || n_burst != 1)
      $display("FAIL back_to_back: got samples=%0d gaps=%0d bursts=%0d exp 64/0/1", n_samples, n_gaps, n_burst);
    else n_pass++;
  endtask

  task automatic test_full_stall();
    int base;
    logic [1:0] ri, rq;
    base = n_pushed;
    for (int c = 0; c < 30 && n_pushed - base < 5; c++) begin
      ri = 2'($urandom_range(0, 3));
      rq = 2'($urandom_range(0, 3));
      cyc0(1, ri, rq, 0);
    end
    n_checks++;
    if (sr0 !== 1'b0 || dc0 !== 3'd4 || ov0 !== 1'b1)
      $display("FAIL full_ready: got ready=%b count=%0d valid=%b exp 0/4/1", sr0, dc0, ov0);
    else n_pass++;
    for (int c = 0; c < 3; c++) cyc0(1, 2'b11, 2'b11, 0);
    n_checks++;
    if (n_pushed - base != 5 || sr0 !== 1'b0)
      $display("FAIL full_block: got pushed=%0d ready=%b exp 5/0", n_pushed - base, sr0);
    else n_pass++;
    drain0();
  endtask

  task automatic test_reset_mid();
    int base;
    base = n_pushed;
    for (int c = 0; c < 20 && n_pushed - base < 4; c++) cyc0(1, 2'(c), 2'(c + 1), 0);
    cyc0(0, 2'b00, 2'b00, 1);
    cyc0(0, 2'b00, 2'b00, 1);
    // now in phase 2 of the held symbol with 3 queued
    rst = 1'b1; sv0 = 1'b0;
    @(negedge clk);
    exp_q.delete(); exp_be = 1'b0; stalled = 1'b0;
    n_checks++;
    if ({ov0, oi0, oq0, of0, be0, sr0, dc0} !== '0)
      $display("FAIL reset_mid: got %h exp 0", {ov0, oi0, oq0, of0, be0, sr0, dc0});
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (sr0 !== 1'b1 || ov0 !== 1'b0 || dc0 !== 3'd0)
      $display("FAIL reset_after: got ready=%b valid=%b count=%0d exp 1/0/0", sr0, ov0, dc0);
    else n_pass++;
    for (int c = 0; c < 10; c++) cyc0(0, 2'b00, 2'b00, 1);
  endtask

  task automatic test_random();
    logic [1:0] ri, rq;
    for (int c = 0; c < 400; c++) begin
      ri = 2'($urandom_range(0, 3));
      rq = 2'($urandom_range(0, 3));
      cyc0(bit'($urandom_range(0, 1)), ri, rq, ($urandom_range(0, 3) != 0));
    end
    drain0();
  endtask

  task automatic test_zero_insert();
    logic [AMP_W-1:0] gi[4], gq[4];
    logic gf[4];
    logic [AMP_W-1:0] ei, eq;
    int n;
    n_checks++;
    if (sr1 !== 1'b1) $display("FAIL zi_ready: got %b exp 1", sr1);
    else n_pass++;
    sv1 = 1'b1; si1 = 2'b11; sq1 = 2'b01; or1 = 1'b1;
    @(negedge clk);
    sv1 = 1'b0;
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      if (ov1 === 1'b1) begin
        gi[n] = oi1; gq[n] = oq1; gf[n] = of1; n++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (n != 4) $display("FAIL zi_count: got %0d exp 4", n);
    else n_pass++;
    for (int k = 0; k < n; k++) begin
      ei = (k == 0) ? AMP_W'(level(2'b11)) : '0;
      eq = (k == 0) ? AMP_W'(level(2'b01)) : '0;
      n_checks++;
      if (gi[k] !== ei || gq[k] !== eq || gf[k] !== (k == 0))
        $display("FAIL zi_sample%0d: got %h/%h/%b exp %h/%h/%b", k, gi[k], gq[k], gf[k], ei, eq, (k == 0));
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if (ov1 !== 1'b0) $display("FAIL zi_idle: got %b exp 0", ov1);
    else n_pass++;
  endtask

  task automatic test_sps1();
    logic [1:0] ci[3], cq[3];
    int n, first_t;
    logic [W-1:0] got, exp;
    for (int k = 0; k < 3; k++) begin
      ci[k] = 2'($urandom_range(0, 3));
      cq[k] = 2'($urandom_range(0, 3));
    end
    or2 = 1'b1;
    n = 0; first_t = -1;
    for (int t = 0; t < 10; t++) begin
      if (t < 3) begin
        n_checks++;
        if (sr2 !== 1'b1) $display("FAIL sps1_ready: got %b exp 1", sr2);
        else n_pass++;
        sv2 = 1'b1; si2 = ci[t]; sq2 = cq[t];
      end else begin
        sv2 = 1'b0;
      end
      @(negedge clk);
      if (ov2 === 1'b1) begin
        if (first_t < 0) first_t = t + 1;
        got = {of2, oi2, oq2};
        n_checks++;
        if (n >= 3) begin
          $display("FAIL sps1_extra: got %h exp none", got);
        end else begin
          exp = {1'b1, AMP_W'(level(ci[n])), AMP_W'(level(cq[n]))};
          if (got !== exp) $display("FAIL sps1_sample%0d: got %h exp %h", n, got, exp);
          else n_pass++;
        end
        n++;
      end
    end
    n_checks++;
    if (n != 3 || first_t != 2)
      $display("FAIL sps1_latency: got samples=%0d first=%0d exp 3/2", n, first_t);
    else n_pass++;
  endtask

  initial begin
    sv0 = 0; si0 = 0; sq0 = 0; or0 = 0;
    sv1 = 0; si1 = 0; sq1 = 0; or1 = 0;
    sv2 = 0; si2 = 0; sq2 = 0; or2 = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_full_stall();
    test_reset_mid();
    test_random();
    test_zero_insert();
    test_sps1();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
